battle_round_ctrl: RTL and testbench
====================================

Name: battle_round_ctrl

Overview:
Parametrised two-player round controller for the board-attack game.
- Holds each player's ship board and runs setup, then alternating turns.
- Resolves each shot as hit or miss, clears hit cells, and tracks shot counts.
- Declares a winner when a board empties.
- Feeds a 2-bit word select to the seven-segment word display block; sits between the debounced button/switch inputs and the display.

Parameters:
CELLS, 16, board width in cells; one bit per cell.
SHOT_W, 8, width of each player's saturating shot counter.

Ports:
clk  in  1  system clock
clr_n  in  1  asynchronous active-low reset
pos_in  in  CELLS  switch vector: ship placement in setup, one-hot target in turns
place_val  in  1  single-cycle pulse: commit pos_in as current setup player's board
fire_val  in  1  single-cycle pulse: fire at pos_in on opponent board
restart  in  1  single-cycle pulse: return to setup, clear all state
turn  out  1  player whose action is expected (0/1)
hit  out  1  one-cycle pulse, last shot hit
miss  out  1  one-cycle pulse, last shot missed
reject  out  1  one-cycle pulse, input pulse refused
alive  out  2  alive[p] = board p nonzero
game_over  out  1  high while in OVER state
winner  out  1  valid when game_over
shots0  out  SHOT_W  player 0 valid shot count
shots1  out  SHOT_W  player 1 valid shot count
word_sel  out  2  display code: 00 setup, 01 P0 turn, 10 P1 turn, 11 game over

Behaviour:
- Reset (clr_n low, async):
  - State SETUP0; both boards 0; shots0/shots1 0; turn 0.
  - hit/miss/reject 0; game_over 0; winner 0; word_sel 00.
- States and transitions:
  - SETUP0: place_val with pos_in != 0 -> board0 <= pos_in, go to SETUP1.
  - SETUP1: same for board1, then go to TURN0.
  - TURN0 / TURN1: handle fire_val as below.
  - OVER: terminal until restart.
- Setup rules:
  - place_val with pos_in == 0 -> reject pulse, stay in state.
  - fire_val in SETUPx -> reject pulse, no state change.
- Turn rules (TURNp, opponent q):
  - fire_val with pos_in not one-hot (zero or more than one bit set) -> reject pulse; no board, counter or turn change.
  - Valid shot, target bit set in board q -> clear that bit; hit pulse.
  - Valid shot, target bit clear in board q -> miss pulse. A repeat shot on a cleared cell counts as a miss.
  - Every valid shot increments shots_p, saturating at 2^SHOT_W-1.
  - If board q becomes zero after the shot -> go to OVER, winner <= p.
  - Otherwise turn alternates: TURNp -> TURNq.
  - place_val in TURNx or OVER -> reject pulse.
- Latency: hit/miss/reject, board update, counter update and state change all register on the clk edge sampling the input pulse; outputs are visible the following cycle.
- turn = 0 in SETUP0/TURN0, 1 in SETUP1/TURN1, holds last value in OVER.
- alive is derived combinationally from the board registers; 2'b00 during SETUP0 is legal.
- game_over = (state == OVER).
- word_sel is a pure function of state.
- Priority: restart > place_val/fire_val. restart acts synchronously from any state: clears boards, counters and winner; goes to SETUP0; no hit/miss/reject pulse that cycle.
- Simultaneous place_val and fire_val: the pulse relevant to the current state is acted on; the other one also raises reject (single reject pulse).
- clr_n low mid-game aborts immediately to the reset values; no partial update completes.
- Inputs are pre-debounced single-cycle pulses. A held level acts on every cycle it is high.

Decomposition:
- Package battle_pkg:
  - state enum (SETUP0, SETUP1, TURN0, TURN1, OVER).
  - word_sel codes WS_SETUP=2'b00, WS_P0=2'b01, WS_P1=2'b10, WS_OVER=2'b11.
- Sub-module shot_eval, parameter CELLS. Purely combinational:
  - Inputs: board, pos_in.
  - Outputs: onehot, is_hit, next_board, board_empty_next.
  - Instantiated once and muxed on turn.
- Boards, counters and FSM live in the top.

Test Plan:
- Reset then place 16'h000F, then place 16'hF000 -> SETUP1 then TURN0; alive=11; word_sel 00 -> 01; turn=0.
- TURN0 fire 16'h1000 -> hit next cycle, board1=16'hE000, shots0=1, turn=1, word_sel=10.
- TURN1 fire 16'h0003 (two bits) -> reject, turn stays 1, shots1=0. Then fire 16'h0100 -> miss, turn=0.
- Sink all four P1 ships over alternating turns -> game_over=1, winner=0, alive=01, word_sel=11. Further fire_val -> reject only.
- Place 16'h0000 in SETUP0 -> reject, still SETUP0. restart asserted together with fire_val in TURN1 -> SETUP0, boards 0, no hit/miss.
- clr_n pulsed low mid-turn with fire_val high -> all outputs at reset values with no clock edge; SHOT_W=2 with 5 shots -> counter saturates at 3.

Source files
------------

// File: rtl/battle_pkg.sv
// rtl/battle_pkg.sv - shared types and display codes for the battle round controller
// Purpose: FSM state enum, word-select display codes and a state-to-word helper.
// Ports: none (package).
package battle_pkg;

  typedef enum logic [2:0] {
    SETUP0 = 3'd0,
    SETUP1 = 3'd1,
    TURN0  = 3'd2,
    TURN1  = 3'd3,
    OVER   = 3'd4
  } state_e;

  localparam logic [1:0] WS_SETUP = 2'b00;
  localparam logic [1:0] WS_P0    = 2'b01;
  localparam logic [1:0] WS_P1    = 2'b10;
  localparam logic [1:0] WS_OVER  = 2'b11;

  function automatic logic [1:0] word_of(state_e s);
    logic [1:0] w;
    w = WS_SETUP;
    case (s)
      SETUP0, SETUP1: w = WS_SETUP;
      TURN0:          w = WS_P0;
      TURN1:          w = WS_P1;
      OVER:           w = WS_OVER;
      default:        w = WS_SETUP;
    endcase
    return w;
  endfunction

endpackage

// File: rtl/battle_round_ctrl_shot_eval.sv
// rtl/battle_round_ctrl_shot_eval.sv - combinational evaluation of one shot against one board
// Purpose: validates the target as one-hot and computes the hit flag and post-shot board.
// Ports:
//   board            in   opponent board before the shot
//   pos_in           in   target vector
//   onehot           out  target has exactly one bit set
//   is_hit           out  valid target lands on a set board cell
//   next_board       out  board with the target cell cleared (unchanged if target invalid)
//   board_empty_next out  next_board is all zero
module shot_eval #(
  parameter int CELLS = 16
) (
  input  logic [CELLS-1:0] board,
  input  logic [CELLS-1:0] pos_in,
  output logic             onehot,
  output logic             is_hit,
  output logic [CELLS-1:0] next_board,
  output logic             board_empty_next
);
  import battle_pkg::*;

  logic [CELLS-1:0] pos_m1;

  // x & (x-1) clears the lowest set bit; zero result means at most one bit was set.
  assign pos_m1           = pos_in - CELLS'(1);
  assign onehot           = (|pos_in) && ~|(pos_in & pos_m1);
  assign is_hit           = onehot && |(board & pos_in);
  assign next_board       = onehot ? (board & ~pos_in) : board;
  assign board_empty_next = ~|next_board;

endmodule

// File: rtl/battle_round_ctrl.sv
// rtl/battle_round_ctrl.sv - two-player board-attack round controller
// Purpose: holds both ship boards, runs setup then alternating turns, resolves shots,
//          counts shots and declares a winner; drives the display word select.
// Ports:
//   clk, clr_n                     clock, asynchronous active-low reset
//   pos_in                         placement vector in setup, one-hot target in turns
//   place_val, fire_val, restart   single-cycle command pulses
//   turn                           player whose action is expected
//   hit, miss, reject              one-cycle result pulses
//   alive                          per-player board-nonzero flags
//   game_over, winner              game finished and winning player
//   shots0, shots1                 saturating valid-shot counters
//   word_sel                       display word code
module battle_round_ctrl #(
  parameter int CELLS  = 16,
  parameter int SHOT_W = 8
) (
  input  logic              clk,
  input  logic              clr_n,
  input  logic [CELLS-1:0]  pos_in,
  input  logic              place_val,
  input  logic              fire_val,
  input  logic              restart,
  output logic              turn,
  output logic              hit,
  output logic              miss,
  output logic              reject,
  output logic [1:0]        alive,
  output logic              game_over,
  output logic              winner,
  output logic [SHOT_W-1:0] shots0,
  output logic [SHOT_W-1:0] shots1,
  output logic [1:0]        word_sel
);
  import battle_pkg::*;

  state_e            state_q, state_d;
  logic [CELLS-1:0]  board0_q, board0_d;
  logic [CELLS-1:0]  board1_q, board1_d;
  logic [SHOT_W-1:0] shots0_q, shots0_d;
  logic [SHOT_W-1:0] shots1_q, shots1_d;
  logic              winner_q, winner_d;
  logic              turn_q, turn_d;
  logic              hit_q, hit_d;
  logic              miss_q, miss_d;
  logic              reject_q, reject_d;

  logic [CELLS-1:0]  target_board;
  logic              sh_onehot;
  logic              sh_is_hit;
  logic [CELLS-1:0]  sh_next;
  logic              sh_empty;

  // Single evaluator: the opponent of the current shooter is board1 in TURN0, board0 in TURN1.
  assign target_board = (state_q == TURN1) ? board0_q : board1_q;

  shot_eval #(.CELLS(CELLS)) u_shot_eval (
    .board            (target_board),
    .pos_in           (pos_in),
    .onehot           (sh_onehot),
    .is_hit           (sh_is_hit),
    .next_board       (sh_next),
    .board_empty_next (sh_empty)
  );

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state_q  <= SETUP0;
      board0_q <= '0;
      board1_q <= '0;
      shots0_q <= '0;
      shots1_q <= '0;
      winner_q <= 1'b0;
      turn_q   <= 1'b0;
      hit_q    <= 1'b0;
      miss_q   <= 1'b0;
      reject_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      board0_q <= board0_d;
      board1_q <= board1_d;
      shots0_q <= shots0_d;
      shots1_q <= shots1_d;
      winner_q <= winner_d;
      turn_q   <= turn_d;
      hit_q    <= hit_d;
      miss_q   <= miss_d;
      reject_q <= reject_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    board0_d = board0_q;
    board1_d = board1_q;
    shots0_d = shots0_q;
    shots1_d = shots1_q;
    winner_d = winner_q;
    turn_d   = turn_q;
    hit_d    = 1'b0;
    miss_d   = 1'b0;
    reject_d = 1'b0;

    if (restart) begin
      state_d  = SETUP0;
      board0_d = '0;
      board1_d = '0;
      shots0_d = '0;
      shots1_d = '0;
      winner_d = 1'b0;
      turn_d   = 1'b0;
    end else begin
      case (state_q)
        SETUP0: begin
          reject_d = fire_val | (place_val & ~|pos_in);
          if (place_val && |pos_in) begin
            board0_d = pos_in;
            state_d  = SETUP1;
            turn_d   = 1'b1;
          end
        end
        SETUP1: begin
          reject_d = fire_val | (place_val & ~|pos_in);
          if (place_val && |pos_in) begin
            board1_d = pos_in;
            state_d  = TURN0;
            turn_d   = 1'b0;
          end
        end
        TURN0, TURN1: begin
          reject_d = place_val | (fire_val & ~sh_onehot);
          if (fire_val && sh_onehot) begin
            hit_d  = sh_is_hit;
            miss_d = ~sh_is_hit;
            if (state_q == TURN0) begin
              board1_d = sh_next;
              shots0_d = (&shots0_q) ? shots0_q : shots0_q + SHOT_W'(1);
            end else begin
              board0_d = sh_next;
              shots1_d = (&shots1_q) ? shots1_q : shots1_q + SHOT_W'(1);
            end
            // turn is left untouched on a win so it keeps naming the winner's turn.
            if (sh_empty) begin
              state_d  = OVER;
              winner_d = (state_q == TURN1);
            end else begin
              state_d = (state_q == TURN0) ? TURN1 : TURN0;
              turn_d  = (state_q == TURN0);
            end
          end
        end
        OVER: begin
          reject_d = place_val | fire_val;
        end
        default: begin
          state_d = SETUP0;
        end
      endcase
    end
  end

  always_comb begin
    word_sel  = word_of(state_q);
    game_over = (state_q == OVER);
    turn      = turn_q;
    winner    = winner_q;
    hit       = hit_q;
    miss      = miss_q;
    reject    = reject_q;
    alive     = {|board1_q, |board0_q};
    shots0    = shots0_q;
    shots1    = shots1_q;
  end

endmodule

// File: tb/tb_battle_round_ctrl.sv
// tb/tb_battle_round_ctrl.sv - self-checking bench for battle_round_ctrl
module tb_battle_round_ctrl;

  logic        clk = 1'b0;
  logic        clr_n = 1'b0;
  logic [15:0] pos_in = '0;
  logic        place_val = 1'b0;
  logic        fire_val = 1'b0;
  logic        restart = 1'b0;

  logic        turn, hit, miss, reject, game_over, winner;
  logic [1:0]  alive, word_sel;
  logic [7:0]  shots0, shots1;

  logic        turn2, hit2, miss2, reject2, game_over2, winner2;
  logic [1:0]  alive2, word_sel2;
  logic [1:0]  shots0_2, shots1_2;

  battle_round_ctrl #(.CELLS(16), .SHOT_W(8)) dut (
    .clk(clk), .clr_n(clr_n), .pos_in(pos_in), .place_val(place_val),
    .fire_val(fire_val), .restart(restart), .turn(turn), .hit(hit),
    .miss(miss), .reject(reject), .alive(alive), .game_over(game_over),
    .winner(winner), .shots0(shots0), .shots1(shots1), .word_sel(word_sel)
  );

  battle_round_ctrl #(.CELLS(16), .SHOT_W(2)) dut2 (
    .clk(clk), .clr_n(clr_n), .pos_in(pos_in), .place_val(place_val),
    .fire_val(fire_val), .restart(restart), .turn(turn2), .hit(hit2),
    .miss(miss2), .reject(reject2), .alive(alive2), .game_over(game_over2),
    .winner(winner2), .shots0(shots0_2), .shots1(shots1_2), .word_sel(word_sel2)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: counts of boards placed, whose shot it is, and plain board arrays.
  int          m_placed;
  bit          m_cur;
  bit          m_over;
  bit          m_win;
  logic [15:0] m_b [2];
  int          m_sh [2];
  bit          e_hit, e_miss, e_rej;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int sat(input int v, input int mx);
    return (v > mx) ? mx : v;
  endfunction

  task automatic model_reset();
    m_placed = 0; m_cur = 0; m_over = 0; m_win = 0;
    m_b[0] = '0; m_b[1] = '0; m_sh[0] = 0; m_sh[1] = 0;
    e_hit = 0; e_miss = 0; e_rej = 0;
  endtask

  task automatic model_step(input bit pl, input bit fi, input bit rs, input logic [15:0] pos);
    int q;
    e_hit = 0; e_miss = 0; e_rej = 0;
    if (rs) begin
      model_reset();
    end else if (m_placed < 2) begin
      if (fi) e_rej = 1;
      if (pl) begin
        if (pos == 16'h0) e_rej = 1;
        else begin
          m_b[m_placed] = pos;
          m_placed++;
          m_cur = (m_placed == 1);
        end
      end
    end else if (m_over) begin
      e_rej = pl | fi;
    end else begin
      if (pl) e_rej = 1;
      if (fi) begin
        if ($countones(pos) != 1) e_rej = 1;
        else begin
          q = m_cur ? 0 : 1;
          if ((m_b[q] & pos) != 0) e_hit = 1; else e_miss = 1;
          m_b[q] = m_b[q] & ~pos;
          m_sh[m_cur]++;
          if (m_b[q] == 0) begin
            m_over = 1;
            m_win  = m_cur;
          end else begin
            m_cur = ~m_cur;
          end
        end
      end
    end
  endtask

  task automatic check_all(input string tag);
    logic [1:0] e_ws;
    logic [1:0] e_alive;
    e_alive = {m_b[1] != 0, m_b[0] != 0};
    if (m_placed < 2)  e_ws = 2'b00;
    else if (m_over)   e_ws = 2'b11;
    else               e_ws = m_cur ? 2'b10 : 2'b01;
    check_eq({tag, ".turn"},      turn,      m_cur);
    check_eq({tag, ".hit"},       hit,       e_hit);
    check_eq({tag, ".miss"},      miss,      e_miss);
    check_eq({tag, ".reject"},    reject,    e_rej);
    check_eq({tag, ".alive"},     alive,     e_alive);
    check_eq({tag, ".game_over"}, game_over, m_over);
    check_eq({tag, ".winner"},    winner,    m_win);
    check_eq({tag, ".shots0"},    shots0,    sat(m_sh[0], 255));
    check_eq({tag, ".shots1"},    shots1,    sat(m_sh[1], 255));
    check_eq({tag, ".word_sel"},  word_sel,  e_ws);
    check_eq({tag, ".w2.turn"},   turn2,     m_cur);
    check_eq({tag, ".w2.hitmiss"}, {hit2, miss2, reject2}, {e_hit, e_miss, e_rej});
    check_eq({tag, ".w2.state"},  {alive2, game_over2, winner2, word_sel2},
             {e_alive, m_over, m_win, e_ws});
    check_eq({tag, ".w2.shots0"}, shots0_2,  sat(m_sh[0], 3));
    check_eq({tag, ".w2.shots1"}, shots1_2,  sat(m_sh[1], 3));
  endtask

  task automatic step(input string tag, input bit pl, input bit fi, input bit rs,
                      input logic [15:0] pos);
    @(negedge clk);
    place_val = pl; fire_val = fi; restart = rs; pos_in = pos;
    model_step(pl, fi, rs, pos);
    @(posedge clk);
    #1;
    place_val = 0; fire_val = 0; restart = 0;
    check_all(tag);
  endtask

  function automatic logic [15:0] pick_bit(input logic [15:0] b);
    int i;
    for (int k = 0; k < 64; k++) begin
      i = $urandom_range(0, 15);
      if (b[i]) return 16'h1 << i;
    end
    for (int k = 0; k < 16; k++) if (b[k]) return 16'h1 << k;
    return 16'h1;
  endfunction

  function automatic logic [15:0] sparse_board();
    logic [15:0] v;
    v = 16'($urandom) & 16'($urandom) & 16'($urandom);
    if (v == 0) v = 16'h1 << $urandom_range(0, 15);
    return v;
  endfunction

  initial begin
    int i, j, r;
    logic [15:0] v;
    model_reset();

    // Reset values before any clock edge, then held through edges.
    #2;
    check_all("reset_pre");
    repeat (2) @(posedge clk);
    #1;
    check_all("reset_hold");
    @(negedge clk);
    clr_n = 1'b1;

    // Directed game.
    step("place0", 1, 0, 0, 16'h000F);
    check_eq("place0.ws_const", word_sel, 2'b00);
    step("place1", 1, 0, 0, 16'hF000);
    check_eq("place1.alive_const", alive, 2'b11);
    check_eq("place1.ws_const", word_sel, 2'b01);
    step("p0_hit", 0, 1, 0, 16'h1000);
    check_eq("p0_hit.hit_const", hit, 1'b1);
    check_eq("p0_hit.shots0_const", shots0, 8'd1);
    check_eq("p0_hit.ws_const", word_sel, 2'b10);
    step("p1_twobit", 0, 1, 0, 16'h0003);
    check_eq("p1_twobit.rej_const", reject, 1'b1);
    step("p1_miss", 0, 1, 0, 16'h0100);
    step("p0_hit2", 0, 1, 0, 16'h2000);
    step("p1_miss2", 0, 1, 0, 16'h0200);
    step("p0_hit3", 0, 1, 0, 16'h4000);
    step("p1_repeat", 0, 1, 0, 16'h0200);
    step("p0_win", 0, 1, 0, 16'h8000);
    check_eq("p0_win.over_const", {game_over, winner, alive, word_sel}, {1'b1, 1'b0, 2'b01, 2'b11});
    check_eq("p0_win.sat2", shots0_2, 2'd3);
    step("over_fire", 0, 1, 0, 16'h0001);
    step("over_place", 1, 0, 0, 16'h0001);
    step("over_both", 1, 1, 0, 16'h0001);
    step("restart", 0, 0, 1, 16'h0000);
    step("place_zero", 1, 0, 0, 16'h0000);
    step("setup_fire", 0, 1, 0, 16'h0001);
    step("setup_both", 1, 1, 0, 16'h0030);
    step("place1b", 1, 0, 0, 16'h0300);
    step("p0_miss", 0, 1, 0, 16'h0001);
    step("turn_both", 1, 1, 0, 16'h0100);
    step("restart_fire", 0, 1, 1, 16'h0010);

    // Asynchronous reset mid-turn with fire_val held.
    step("a_place0", 1, 0, 0, 16'h00F0);
    step("a_place1", 1, 0, 0, 16'h0F00);
    step("a_fire", 0, 1, 0, 16'h0100);
    @(negedge clk);
    pos_in = 16'h0010; fire_val = 1'b1;
    #2;
    clr_n = 1'b0;
    #1;
    model_reset();
    check_all("async_now");
    @(posedge clk);
    #1;
    check_all("async_edge");
    @(negedge clk);
    fire_val = 1'b0;
    clr_n = 1'b1;

    // Long miss exchange to saturate the 8-bit counters.
    step("l_place0", 1, 0, 0, 16'h0001);
    step("l_place1", 1, 0, 0, 16'h8000);
    for (int k = 0; k < 265; k++) begin
      step("l_p0", 0, 1, 0, 16'h4000);
      step("l_p1", 0, 1, 0, 16'h0002);
    end
    check_eq("long.sat8", shots0, 8'd255);
    step("l_win", 0, 1, 0, 16'h8000);

    // Randomized games.
    for (int g = 0; g < 40; g++) begin
      step("r_restart", 0, $urandom_range(0, 1), 1, 16'($urandom));
      if ($urandom_range(0, 3) == 0) step("r_place_zero", 1, 0, 0, 16'h0);
      step("r_place0", 1, $urandom_range(0, 1), 0, sparse_board());
      step("r_place1", 1, 0, 0, sparse_board());
      for (int t = 0; t < 80 && !m_over; t++) begin
        r = $urandom_range(0, 15);
        j = m_cur ? 0 : 1;
        if (r < 8) begin
          step("r_fire", 0, 1, 0, 16'h1 << $urandom_range(0, 15));
        end else if (r < 12) begin
          step("r_aim", 0, 1, 0, pick_bit(m_b[j]));
        end else if (r == 12) begin
          step("r_zero", 0, 1, 0, 16'h0);
        end else if (r == 13) begin
          i = $urandom_range(0, 15);
          v = (16'h1 << i) | (16'h1 << ((i + 1 + $urandom_range(0, 14)) % 16));
          step("r_multi", 0, 1, 0, v);
        end else if (r == 14) begin
          step("r_both", 1, 1, 0, pick_bit(m_b[j]));
        end else begin
          step("r_place", 1, 0, 0, 16'($urandom));
        end
      end
      if (m_over) step("r_over_fire", $urandom_range(0, 1), 1, 0, 16'($urandom));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    n_fail++;
    $display("FAIL timeout: simulation exceeded time budget");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
